// File: rtl/key_debounce_module_pkg.sv
// Shared types and default timing constants for the key debounce block.
// Holds the debounce FSM state encoding and the project-wide default cycle
// counts, so the LED modules and future key instances share one source.
package key_debounce_module_pkg;

   // Default timing constants (cycles of the system clock)
   localparam int unsigned KEY_DEBOUNCE_CYCLES_DEF = 1_000_000;
   localparam int unsigned KEY_LONG_CYCLES_DEF     = 50_000_000;
   localparam int unsigned KEY_CNT_W_DEF           = 32;

   // Debounce FSM states
   typedef enum logic [1:0] {
      ST_IDLE        = 2'd0,
      ST_PRESS_CHK   = 2'd1,
      ST_HELD        = 2'd2,
      ST_RELEASE_CHK = 2'd3
   } key_state_e;

endpackage : key_debounce_module_pkg

// File: rtl/key_sync_module.sv
// Two-flop synchroniser for an asynchronous, active-low key pin.
// Both flops reset to 1 so a reset looks like "released" downstream.
// Ports:
//   clk      in  system clock, rising edge
//   rst_n    in  asynchronous active-low reset
//   key_raw  in  raw pin, asynchronous to clk
//   key_sync out synchronised pin level (second flop)
module key_sync_module (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic key_sync
);

   logic s1;

   // Metastability filter chain
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1       <= 1'b1;
         key_sync <= 1'b1;
      end else begin
         s1       <= key_raw;
         key_sync <= s1;
      end
   end

endmodule : key_sync_module

// File: rtl/key_debounce_module.sv
// Push-button debouncer: turns one raw, active-low, bouncing key pin into a
// stable pressed level plus one-cycle press, release and long-press pulses.
// Ports:
//   CLK          in  system clock, rising edge
//   RSTn         in  asynchronous active-low reset
//   KEY_In       in  raw key pin, 0 = pressed, asynchronous to CLK
//   KEY_Level    out debounced level, 1 = pressed
//   KEY_Press    out one-cycle pulse on an accepted press
//   KEY_Release  out one-cycle pulse on an accepted release
//   KEY_Long     out one-cycle pulse, once per press, after LONG_CYCLES held
module key_debounce_module
   import key_debounce_module_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_CYCLES_DEF,
   parameter int unsigned LONG_CYCLES     = KEY_LONG_CYCLES_DEF,
   parameter int unsigned CNT_W           = KEY_CNT_W_DEF
) (
   input  logic CLK,
   input  logic RSTn,
   input  logic KEY_In,
   output logic KEY_Level,
   output logic KEY_Press,
   output logic KEY_Release,
   output logic KEY_Long
);

   localparam logic [CNT_W-1:0] DCNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] LCNT_LAST = CNT_W'(LONG_CYCLES - 1);

   logic             k;
   key_state_e       state, state_nxt;
   logic [CNT_W-1:0] dcnt, dcnt_nxt;
   logic [CNT_W-1:0] lcnt, lcnt_nxt;
   logic [CNT_W-1:0] lcnt_sat;
   logic             long_done, long_done_nxt;
   logic             long_hit;
   logic             level_nxt, press_nxt, release_nxt, long_nxt;

   // Pin synchroniser; only its output is used below
   key_sync_module u_sync (
      .clk      (CLK),
      .rst_n    (RSTn),
      .key_raw  (KEY_In),
      .key_sync (k)
   );

   // Long-press counter step, saturating so it never wraps
   assign lcnt_sat = (lcnt == LCNT_LAST) ? lcnt : lcnt + CNT_W'(1);
   assign long_hit = (lcnt_sat == LCNT_LAST) && !long_done;

   // State and counter registers
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state     <= ST_IDLE;
         dcnt      <= '0;
         lcnt      <= '0;
         long_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         dcnt      <= dcnt_nxt;
         lcnt      <= lcnt_nxt;
         long_done <= long_done_nxt;
      end
   end

   // Registered outputs
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         KEY_Level   <= 1'b0;
         KEY_Press   <= 1'b0;
         KEY_Release <= 1'b0;
         KEY_Long    <= 1'b0;
      end else begin
         KEY_Level   <= level_nxt;
         KEY_Press   <= press_nxt;
         KEY_Release <= release_nxt;
         KEY_Long    <= long_nxt;
      end
   end

   // Next-state and pulse decode
   always_comb begin
      state_nxt     = state;
      dcnt_nxt      = dcnt;
      lcnt_nxt      = lcnt;
      long_done_nxt = long_done;
      level_nxt     = KEY_Level;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      long_nxt      = 1'b0;

      case (state)
         ST_IDLE: begin
            dcnt_nxt = '0;
            if (!k) begin
               state_nxt = ST_PRESS_CHK;
            end
         end

         ST_PRESS_CHK: begin
            if (k) begin
               state_nxt = ST_IDLE;
               dcnt_nxt  = '0;
            end else if (dcnt == DCNT_LAST) begin
               state_nxt     = ST_HELD;
               dcnt_nxt      = '0;
               lcnt_nxt      = '0;
               long_done_nxt = 1'b0;
               press_nxt     = 1'b1;
               level_nxt     = 1'b1;
            end else begin
               dcnt_nxt = dcnt + CNT_W'(1);
            end
         end

         ST_HELD: begin
            lcnt_nxt = lcnt_sat;
            if (long_hit) begin
               long_nxt      = 1'b1;
               long_done_nxt = 1'b1;
            end
            if (k) begin
               state_nxt = ST_RELEASE_CHK;
               dcnt_nxt  = '0;
            end
         end

         ST_RELEASE_CHK: begin
            if (k && (dcnt == DCNT_LAST)) begin
               // Release wins; a long pulse may not follow or coincide with it
               state_nxt   = ST_IDLE;
               dcnt_nxt    = '0;
               release_nxt = 1'b1;
               level_nxt   = 1'b0;
            end else begin
               lcnt_nxt = lcnt_sat;
               if (long_hit) begin
                  long_nxt      = 1'b1;
                  long_done_nxt = 1'b1;
               end
               if (!k) begin
                  state_nxt = ST_HELD;
               end else begin
                  dcnt_nxt = dcnt + CNT_W'(1);
               end
            end
         end

         default: begin
            state_nxt = ST_IDLE;
            dcnt_nxt  = '0;
         end
      endcase
   end

endmodule : key_debounce_module
